// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter sharing one single-port template ROM between two requesters.
// Whole bursts are granted; a ROM_LAT-deep tag pipeline steers returned words to their owner.
module rom_burst_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] len0,
    output logic                  ack0,
    output logic                  dv0,
    output logic [DATA_WIDTH-1:0] data0,
    output logic                  last0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] len1,
    output logic                  ack1,
    output logic                  dv1,
    output logic [DATA_WIDTH-1:0] data1,
    output logic                  last1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remain;
    logic                  owner;
    logic                  rr_ptr;
    logic                  grant_vld;
    logic                  grant_id;
    logic                  issue;
    logic                  issue_last;

    logic [ROM_LAT-1:0]    tag_vld_p;
    logic [ROM_LAT-1:0]    tag_own_p;
    logic [ROM_LAT-1:0]    tag_last_p;
    logic                  ret_vld;
    logic                  ret_own;
    logic                  ret_last;

    assign rom_addr   = cur_addr;
    assign issue      = (state == BURST);
    assign issue_last = (remain == '0);
    assign ret_vld    = tag_vld_p[ROM_LAT-1];
    assign ret_own    = tag_own_p[ROM_LAT-1];
    assign ret_last   = tag_last_p[ROM_LAT-1];

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_vld = 1'b1;
                    // rr_ptr names the port that wins a tie
                    grant_id  = (req0 && req1) ? rr_ptr : req1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (issue_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue stage: arbitration, address sequencing, ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            remain   <= '0;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
        end else begin
            state <= state_nxt;
            ack0  <= grant_vld && !grant_id;
            ack1  <= grant_vld && grant_id;
            if (grant_vld) begin
                cur_addr <= grant_id ? addr1 : addr0;
                remain   <= grant_id ? len1 : len0;
                owner    <= grant_id;
                rr_ptr   <= ~grant_id;
            end else if (issue && !issue_last) begin
                // Address holds on the final issue so rom_addr keeps it through IDLE
                cur_addr <= cur_addr + ADDR_WIDTH'(1);
                remain   <= remain - ADDR_WIDTH'(1);
            end
        end
    end

    // Tag stages: follow each issued address through the ROM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_p  <= '0;
            tag_own_p  <= '0;
            tag_last_p <= '0;
        end else begin
            tag_vld_p[0]  <= issue;
            tag_own_p[0]  <= owner;
            tag_last_p[0] <= issue && issue_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld_p[i]  <= tag_vld_p[i-1];
                tag_own_p[i]  <= tag_own_p[i-1];
                tag_last_p[i] <= tag_last_p[i-1];
            end
        end
    end

    // Return stage: register ROM data into the owning port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv0   <= 1'b0;
            dv1   <= 1'b0;
            last0 <= 1'b0;
            last1 <= 1'b0;
            data0 <= '0;
            data1 <= '0;
        end else begin
            dv0   <= ret_vld && !ret_own;
            dv1   <= ret_vld && ret_own;
            last0 <= ret_vld && !ret_own && ret_last;
            last1 <= ret_vld && ret_own && ret_last;
            if (ret_vld && !ret_own) data0 <= rom_rd_data;
            if (ret_vld && ret_own)  data1 <= rom_rd_data;
        end
    end

endmodule
